saradc_seq: RTL
===============

# saradc_seq

Parametrised digital sequencer for the SAR ADC macro, replacing the fixed single-channel 10-bit conversion path. It drives the capacitive DAC code and sampling switch, reads the comparator, and scans multiple input channels round-robin. Per channel it averages 2^N samples and applies a stored offset calibration, then presents a corrected result with a one-cycle valid strobe. The outputs feed the logic-analyser/Wishbone result registers in the user project wrapper.

## Interface
- RES, 10, conversion resolution in bits (≥4)
- NCH, 4, number of analog channels (≥1)
- AVG_MAX, 3, maximum log2 sample count; calibration always uses 2^AVG_MAX samples
- SETTLE, 2, sampling cycles per sample (≥1)
- clk  in  1  system clock (wb_clk_i at top)
- rstn  in  1  reset; one clock; reset is synchronous and active-low
- en  in  1  level; high = run continuous scan
- cal  in  1  calibration request; any cycle high sets a sticky pending flag
- ch_mask  in  NCH  enabled channels
- avg_log2  in  $clog2(AVG_MAX+1)  samples per result = 2^min(avg_log2, AVG_MAX)
- cmp  in  1  comparator; 1 = input ≥ DAC code
- dac_code  out  RES  DAC trial code
- sample  out  1  sampling switch closed
- cal_mode  out  1  inputs shorted for offset measurement
- ch_sel  out  $clog2(NCH) (min 1)  analog mux select
- result  out  RES  corrected average
- result_ch  out  $clog2(NCH)  channel of result
- valid  out  1  one-cycle result strobe
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, SAMPLE, CONVERT, OUTPUT.
- IDLE: if cal_pending, go to SAMPLE with cal_mode=1. Else, if en and ch_mask≠0, go to SAMPLE on the next enabled channel after the last one converted, round-robin with wrap; the first after reset starts at channel 0. Else stay in IDLE.
- SAMPLE: sample=1 for SETTLE cycles; dac_code=0.
- CONVERT: RES cycles. In cycle k, bit i=RES-1-k is set on dac_code on top of the bits already decided. At the cycle end, the bit is kept if cmp=1 and cleared otherwise. The final code is added to accumulator acc, RES+AVG_MAX bits.
- After each sample: if the sample count < 2^n, go back to SAMPLE. Otherwise avg = acc >> n (truncating).
  - Normal mode: go to OUTPUT.
  - Cal mode: n=AVG_MAX; offset = avg − 2^(RES-1) as a signed RES+1-bit value; clear cal_pending and cal_mode; return to IDLE with no valid strobe.
- OUTPUT: result = clamp(avg − offset, 0, 2^RES−1); result_ch = channel; valid=1 for one cycle. Then go to SAMPLE for the next channel if en and ch_mask≠0, or to IDLE when cal_pending or when that condition fails.
- ch_mask and avg_log2 are captured at each channel start; changes mid-burst are ignored.
- en low mid-burst: finish the burst, output it, then go to IDLE.
- cal asserted mid-burst: latched; taken after that channel's OUTPUT.
- result and result_ch hold until the next valid.

## Timing
- Reset values: dac_code 0, sample 0, cal_mode 0, ch_sel 0, result 0, result_ch 0, valid 0, busy 0, offset 0, cal_pending 0, acc 0.
- Reset mid-operation returns all state and outputs to reset values at that edge.
- Per sample: SETTLE+RES cycles.
- Result latency: valid is high in the cycle beginning 2^n·(SETTLE+RES)+1 edges after the edge at which IDLE samples en=1. With defaults and n=0 this is 13 edges.
- Continuous throughput: one result per 2^n·(SETTLE+RES)+1 cycles.
- Calibration duration: 2^AVG_MAX·(SETTLE+RES)+1 cycles, from the IDLE edge to the return to IDLE.

## Structure
- Package saradc_seq_pkg holds:
  - the state enum
  - the clamp/saturating-subtract function
- Sub-module sar_bit_engine (RES bits) implements the successive-approximation register.
  - Inputs: start, cmp.
  - Outputs: dac_code, code, done.
- The top level holds:
  - the FSM
  - the channel scan
  - the accumulator
  - the offset register

## Test plan
- Defaults, n=0, offset 0, model vin=0x2A5 on ch0, mask=0001 → result=0x2A5, result_ch=0, valid at 13 edges, repeating every 13 cycles.
- mask=1010, n=2, per-sample vin codes 0x100,0x101,0x102,0x103 on ch1 → result=0x101 for ch1, then ch3, then ch1; valid period 49 cycles.
- cal pulse, model code 0x205 while cal_mode → offset=+5, no valid; then vin 0x2A5 → 0x2A0; vin 0x003 → 0x000 (clamp).
- Cal code 0x1FD (offset −3), vin 0x3FE → 0x3FF (clamp high).
- en drops during sample 2 of 4 → burst completes, one valid, then IDLE/busy=0. mask=0 with en=1 → busy stays 0.
- rstn low mid-CONVERT → all outputs are reset values at the next edge; offset is cleared.

Source files
------------

// File: rtl/saradc_seq_pkg.sv
// Shared types and arithmetic helpers for the SAR ADC sequencer.
package saradc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_e;

    localparam int CALC_W = 32;

    // Signed a - b, saturated to the unsigned range [0, 2^res - 1].
    function automatic logic [CALC_W-1:0] sat_sub(
        input logic signed [CALC_W-1:0] a,
        input logic signed [CALC_W-1:0] b,
        input int unsigned              res
    );
        logic signed [CALC_W-1:0] diff;
        logic signed [CALC_W-1:0] hi;
        diff = a - b;
        hi   = $signed((32'd1 << res) - 32'd1);
        if (diff < 32'sd0) begin
            sat_sub = 32'd0;
        end else if (diff > hi) begin
            sat_sub = hi;
        end else begin
            sat_sub = diff;
        end
    endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// Successive-approximation register: one bit decided per cycle, MSB first.
module sar_bit_engine #(
    parameter int RES = 10
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start,
    input  logic           cmp,
    output logic [RES-1:0] dac_code,
    output logic [RES-1:0] code,
    output logic           done
);

    logic [RES-1:0] dac_r;
    logic [RES-1:0] mask_r;
    logic           active_r;
    logic [RES-1:0] decided_s;

    // Trial bit is kept when the input is at or above the trial code.
    always_comb begin
        decided_s = cmp ? dac_r : (dac_r & ~mask_r);
    end

    assign dac_code = dac_r;
    assign code     = decided_s;
    assign done     = active_r & mask_r[0];

    // Trial code / bit pointer sequencing.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dac_r    <= {RES{1'b0}};
            mask_r   <= {RES{1'b0}};
            active_r <= 1'b0;
        end else if (start) begin
            dac_r    <= {1'b1, {(RES-1){1'b0}}};
            mask_r   <= {1'b1, {(RES-1){1'b0}}};
            active_r <= 1'b1;
        end else if (active_r && mask_r[0]) begin
            dac_r    <= {RES{1'b0}};
            mask_r   <= {RES{1'b0}};
            active_r <= 1'b0;
        end else if (active_r) begin
            dac_r    <= decided_s | (mask_r >> 1);
            mask_r   <= mask_r >> 1;
            active_r <= 1'b1;
        end else begin
            dac_r    <= dac_r;
            mask_r   <= mask_r;
            active_r <= active_r;
        end
    end

endmodule

// File: rtl/saradc_seq.sv
// Multi-channel SAR ADC sequencer: round-robin scan, 2^n averaging, offset calibration.
module saradc_seq
    import saradc_seq_pkg::*;
#(
    parameter int RES     = 10,
    parameter int NCH     = 4,
    parameter int AVG_MAX = 3,
    parameter int SETTLE  = 2,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AL_W   = (AVG_MAX > 0) ? $clog2(AVG_MAX + 1) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic            cal,
    input  logic [NCH-1:0]  ch_mask,
    input  logic [AL_W-1:0] avg_log2,
    input  logic            cmp,
    output logic [RES-1:0]  dac_code,
    output logic            sample,
    output logic            cal_mode,
    output logic [CH_W-1:0] ch_sel,
    output logic [RES-1:0]  result,
    output logic [CH_W-1:0] result_ch,
    output logic            valid,
    output logic            busy
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int ACC_W = RES + AVG_MAX;
    localparam int CNT_W = AVG_MAX + 1;

    state_e            state_r, state_s;
    logic [SET_W-1:0]  settle_r, settle_s;
    logic [CNT_W-1:0]  smp_cnt_r, smp_cnt_s, smp_inc_s;
    logic [ACC_W-1:0]  acc_r, acc_s, avg_full_s;
    logic [AL_W-1:0]   n_r, n_s, al_clip_s;
    logic [CH_W-1:0]   ch_sel_r, ch_sel_s, last_ch_r, last_ch_s, base_s, next_ch_s;
    logic              cal_mode_r, cal_mode_s, cal_pending_r, cal_clr_s;
    logic signed [RES:0] offset_r, offset_s;
    logic [RES-1:0]    result_r, result_s, avg_s;
    logic [CH_W-1:0]   result_ch_r, result_ch_s;
    logic              valid_r, valid_s, sample_r, busy_r, start_s, found_s;
    logic [CALC_W-1:0] sat_s;
    logic [RES-1:0]    eng_code_s;
    logic              eng_done_s;

    sar_bit_engine #(.RES(RES)) u_engine (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start_s),
        .cmp      (cmp),
        .dac_code (dac_code),
        .code     (eng_code_s),
        .done     (eng_done_s)
    );

    // Round-robin: first enabled channel strictly after the base, wrapping.
    always_comb begin
        base_s    = (state_r == ST_OUTPUT) ? ch_sel_r : last_ch_r;
        next_ch_s = base_s;
        found_s   = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            logic [CH_W-1:0] idx_v;
            logic            hit_v;
            idx_v     = CH_W'((int'(base_s) + i) % NCH);
            hit_v     = !found_s && ch_mask[idx_v];
            next_ch_s = hit_v ? idx_v : next_ch_s;
            found_s   = found_s | hit_v;
        end
    end

    // FSM next state, datapath updates and next output values.
    always_comb begin
        state_s     = state_r;
        settle_s    = settle_r;
        smp_cnt_s   = smp_cnt_r;
        acc_s       = acc_r;
        n_s         = n_r;
        ch_sel_s    = ch_sel_r;
        last_ch_s   = last_ch_r;
        cal_mode_s  = cal_mode_r;
        offset_s    = offset_r;
        result_s    = result_r;
        result_ch_s = result_ch_r;
        valid_s     = 1'b0;
        start_s     = 1'b0;
        cal_clr_s   = 1'b0;
        al_clip_s   = (int'(avg_log2) > AVG_MAX) ? AL_W'(AVG_MAX) : avg_log2;
        smp_inc_s   = smp_cnt_r + CNT_W'(1);
        avg_full_s  = acc_r >> n_r;
        avg_s       = avg_full_s[RES-1:0];
        sat_s       = sat_sub($signed({{(CALC_W-RES){1'b0}}, avg_s}),
                              $signed({{(CALC_W-RES-1){offset_r[RES]}}, offset_r}), RES);
        case (state_r)
            ST_IDLE: begin
                if (cal_pending_r) begin
                    state_s    = ST_SAMPLE;
                    cal_mode_s = 1'b1;
                    n_s        = AL_W'(AVG_MAX);
                    settle_s   = {SET_W{1'b0}};
                    smp_cnt_s  = {CNT_W{1'b0}};
                    acc_s      = {ACC_W{1'b0}};
                end else if (en && (ch_mask != {NCH{1'b0}})) begin
                    state_s   = ST_SAMPLE;
                    ch_sel_s  = next_ch_s;
                    n_s       = al_clip_s;
                    settle_s  = {SET_W{1'b0}};
                    smp_cnt_s = {CNT_W{1'b0}};
                    acc_s     = {ACC_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                if (settle_r == SET_W'(SETTLE - 1)) begin
                    state_s  = ST_CONVERT;
                    start_s  = 1'b1;
                    settle_s = {SET_W{1'b0}};
                end else begin
                    settle_s = settle_r + SET_W'(1);
                end
            end
            ST_CONVERT: begin
                if (eng_done_s) begin
                    acc_s     = acc_r + ACC_W'(eng_code_s);
                    smp_cnt_s = smp_inc_s;
                    state_s   = (smp_inc_s == (CNT_W'(1) << n_r)) ? ST_OUTPUT : ST_SAMPLE;
                end else begin
                    state_s = ST_CONVERT;
                end
            end
            ST_OUTPUT: begin
                if (cal_mode_r) begin
                    offset_s   = $signed({1'b0, avg_s}) - $signed({2'b01, {(RES-1){1'b0}}});
                    cal_mode_s = 1'b0;
                    cal_clr_s  = 1'b1;
                    state_s    = ST_IDLE;
                end else begin
                    result_s    = sat_s[RES-1:0];
                    result_ch_s = ch_sel_r;
                    valid_s     = 1'b1;
                    last_ch_s   = ch_sel_r;
                    if (!cal_pending_r && en && (ch_mask != {NCH{1'b0}})) begin
                        state_s   = ST_SAMPLE;
                        ch_sel_s  = next_ch_s;
                        n_s       = al_clip_s;
                        settle_s  = {SET_W{1'b0}};
                        smp_cnt_s = {CNT_W{1'b0}};
                        acc_s     = {ACC_W{1'b0}};
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r       <= ST_IDLE;
            settle_r      <= {SET_W{1'b0}};
            smp_cnt_r     <= {CNT_W{1'b0}};
            acc_r         <= {ACC_W{1'b0}};
            n_r           <= {AL_W{1'b0}};
            ch_sel_r      <= {CH_W{1'b0}};
            last_ch_r     <= CH_W'(NCH - 1);
            cal_mode_r    <= 1'b0;
            cal_pending_r <= 1'b0;
            offset_r      <= {(RES+1){1'b0}};
            result_r      <= {RES{1'b0}};
            result_ch_r   <= {CH_W{1'b0}};
            valid_r       <= 1'b0;
            sample_r      <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            settle_r      <= settle_s;
            smp_cnt_r     <= smp_cnt_s;
            acc_r         <= acc_s;
            n_r           <= n_s;
            ch_sel_r      <= ch_sel_s;
            last_ch_r     <= last_ch_s;
            cal_mode_r    <= cal_mode_s;
            cal_pending_r <= cal | (cal_pending_r & ~cal_clr_s);
            offset_r      <= offset_s;
            result_r      <= result_s;
            result_ch_r   <= result_ch_s;
            valid_r       <= valid_s;
            sample_r      <= (state_s == ST_SAMPLE);
            busy_r        <= (state_s != ST_IDLE);
        end
    end

    assign sample    = sample_r;
    assign cal_mode  = cal_mode_r;
    assign ch_sel    = ch_sel_r;
    assign result    = result_r;
    assign result_ch = result_ch_r;
    assign valid     = valid_r;
    assign busy      = busy_r;

endmodule
